// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline sequencer: post-reset flush, load-use bubbles, EX redirect flushes and
// data-memory waits with timeout fault. Define PIPE_PERF_CNT_EN to add stall/bubble/flush counters.
module pipeline_hazard_controller #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read_ex,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic       redirect_ex,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_clear,
    output logic       id_ex_en,
    output logic       id_ex_clear,
    output logic       ex_mem_en,
    output logic       ex_mem_clear,
    output logic       mem_wb_en,
    output logic       mem_wb_clear,
    output logic       mem_fault
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_MEM_WAIT,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic w_load_use;
    logic w_stall;
    logic w_flush;
    logic w_bubble;

    assign w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                        ((rs1_used_id && (rs1_id == rd_ex)) ||
                         (rs2_used_id && (rs2_id == rd_ex)));

    // Mutually exclusive action decode; MEM_WAIT release re-runs the RUN priority chain.
    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            S_RUN: begin
                w_stall  = dmem_req_mem && !dmem_ready;
                w_flush  = !w_stall && redirect_ex;
                w_bubble = !w_stall && !redirect_ex && w_load_use;
            end
            S_MEM_WAIT: begin
                w_stall  = !dmem_ready;
                w_flush  = dmem_ready && redirect_ex;
                w_bubble = dmem_ready && !redirect_ex && w_load_use;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_next_cnt = r_cnt + 1'b1;
                if (r_cnt == INIT_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
            end
            S_RUN: begin
                if (w_stall) begin
                    w_next_state = S_MEM_WAIT;
                    w_next_cnt   = CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else begin
                    if (r_cnt != '1) begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                    if ((MEM_TIMEOUT != 0) && (r_cnt == TIMEOUT_CNT)) begin
                        w_next_state = S_FAULT;
                    end
                end
            end
            S_FAULT: ;
            default: begin
                w_next_state = S_INIT;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_clear  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_clear = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_clear = 1'b0;
        mem_fault    = 1'b0;
        case (r_state)
            S_INIT: begin
                pc_en        = 1'b0;
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                ex_mem_clear = 1'b1;
                mem_wb_clear = 1'b1;
            end
            S_FAULT: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                mem_fault = 1'b1;
            end
            default: begin
                if (w_stall) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_clear = 1'b1;
                end
                if (w_flush) begin
                    if_id_clear = 1'b1;
                    id_ex_clear = 1'b1;
                end
                if (w_bubble) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_clear = 1'b1;
                end
            end
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_count;
    logic [31:0] r_flush_count;

    // Action strobes are already zero in INIT and FAULT, which inhibits counting there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_bubble) r_bubble_count <= r_bubble_count + 32'd1;
            if (w_flush)  r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
    assign flush_count  = r_flush_count;
`endif

endmodule
